shift_rotate_pipe: RTL and testbench

Pipelined, parametrised shift/rotate execution unit for the SPU-lite even pipe, the successor to the combinational simple-fixed-2 datapath. It decodes 16 RR/RI7 shift, rotate, rotate-and-mask and rotate-and-mask-algebraic opcodes. Ops work on word or halfword elements across a WIDTH-bit register. Results emerge after a fixed, parametrised latency, with stall and flush support for the issue/forwarding logic.

---
 rtl/shift_rotate_pipe.sv | 154 +++++++++++++++
 tb/tb_shift_rotate_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_pipe.sv
// Pipelined shift/rotate unit: word or halfword elements across a WIDTH-bit register,
// fixed STAGES-cycle latency, with stall (hold) and flush (kill) control.
module shift_rotate_pipe #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [0:31]      instruction,
  input  logic [0:WIDTH-1] ra_data,
  input  logic [0:WIDTH-1] rb_data,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic             wr_en_out,
  output logic [0:6]       rt_addr_out,
  output logic [0:WIDTH-1] rt_data_out
);

  localparam int NW = WIDTH / 32;
  localparam int NH = WIDTH / 16;

  // Handshake: an op is taken when valid_in & !stall & !flush; stall freezes every
  // stage, flush clears every stage (and the incoming op) and wins over stall.

  // All 16 opcodes share 00001 x 11 h kk: x = immediate form, h = halfword,
  // kk = 00 rot, 11 shl, 01 rotm, 10 rotma.
  logic       legal;
  logic       is_imm;
  logic       is_half;
  logic [1:0] kind;
  logic [6:0] i7;
  logic [6:0] rt;
  logic       unused_bits;

  assign legal       = (instruction[0:4] == 5'b00001) && (instruction[6:7] == 2'b11);
  assign is_imm      = instruction[5];
  assign is_half     = instruction[8];
  assign kind        = instruction[9:10];
  assign i7          = instruction[11:17];
  assign rt          = instruction[25:31];
  assign unused_bits = ^instruction[18:24];

  function automatic logic [31:0] word_op(input logic [31:0] a, input logic [31:0] cnt,
                                          input logic [1:0] k);
    logic [5:0]  s_l;
    logic [5:0]  s_r;
    logic [63:0] dbl;
    logic [31:0] r;
    s_l = cnt[5:0];
    s_r = 6'd0 - cnt[5:0];
    dbl = {a, a} << cnt[4:0];
    case (k)
      2'b00:   r = dbl[63:32];
      2'b11:   r = s_l[5] ? '0 : (a << s_l[4:0]);
      2'b01:   r = s_r[5] ? '0 : (a >> s_r[4:0]);
      default: r = s_r[5] ? {32{a[31]}} : 32'($signed(a) >>> s_r[4:0]);
    endcase
    return r;
  endfunction

  function automatic logic [15:0] half_op(input logic [15:0] a, input logic [15:0] cnt,
                                          input logic [1:0] k);
    logic [4:0]  s_l;
    logic [4:0]  s_r;
    logic [31:0] dbl;
    logic [15:0] r;
    s_l = cnt[4:0];
    s_r = 5'd0 - cnt[4:0];
    dbl = {a, a} << cnt[3:0];
    case (k)
      2'b00:   r = dbl[31:16];
      2'b11:   r = s_l[4] ? '0 : (a << s_l[3:0]);
      2'b01:   r = s_r[4] ? '0 : (a >> s_r[3:0]);
      default: r = s_r[4] ? {16{a[15]}} : 16'($signed(a) >>> s_r[3:0]);
    endcase
    return r;
  endfunction

  logic [0:WIDTH-1] word_res;
  logic [0:WIDTH-1] half_res;
  logic [31:0]      cnt_w;
  logic [15:0]      cnt_h;

  always_comb begin
    word_res = '0;
    half_res = '0;
    cnt_w    = '0;
    cnt_h    = '0;
    for (int j = 0; j < NW; j++) begin
      cnt_w = is_imm ? {{25{i7[6]}}, i7} : rb_data[32*j +: 32];
      word_res[32*j +: 32] = word_op(ra_data[32*j +: 32], cnt_w, kind);
    end
    for (int h = 0; h < NH; h++) begin
      cnt_h = is_imm ? {{9{i7[6]}}, i7} : rb_data[16*h +: 16];
      half_res[16*h +: 16] = half_op(ra_data[16*h +: 16], cnt_h, kind);
    end
  end

  // Bubbles enter stage 1 with zeroed payload so rt_data_out is 0 whenever valid_out is 0.
  logic             v_d;
  logic             w_d;
  logic [6:0]       a_d;
  logic [0:WIDTH-1] d_d;

  always_comb begin
    v_d = valid_in;
    w_d = valid_in & legal;
    a_d = valid_in ? rt : 7'd0;
    d_d = '0;
    if (valid_in && legal) d_d = is_half ? half_res : word_res;
  end

  logic             v_q [STAGES];
  logic             w_q [STAGES];
  logic [6:0]       a_q [STAGES];
  logic [0:WIDTH-1] d_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        w_q[i] <= 1'b0;
        a_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        w_q[i] <= 1'b0;
        a_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= v_d;
      w_q[0] <= w_d;
      a_q[0] <= a_d;
      d_q[0] <= d_d;
      for (int i = 1; i < STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        w_q[i] <= w_q[i-1];
        a_q[i] <= a_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign valid_out   = v_q[STAGES-1];
  assign wr_en_out   = w_q[STAGES-1];
  assign rt_addr_out = a_q[STAGES-1];
  assign rt_data_out = d_q[STAGES-1];

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Randomised and directed bench for shift_rotate_pipe: an arithmetic reference model
// feeds a scoreboard keyed by pipeline-advance count, so timing and data are both checked.
module tb_shift_rotate_pipe;
  localparam int WIDTH  = 128;
  localparam int STAGES = 4;
  localparam int EW     = 32 + 1 + 7 + WIDTH;

  logic             clk;
  logic             reset_n;
  logic             valid_in;
  logic [0:31]      instruction;
  logic [0:WIDTH-1] ra_data;
  logic [0:WIDTH-1] rb_data;
  logic             stall;
  logic             flush;
  logic             valid_out;
  logic             wr_en_out;
  logic [0:6]       rt_addr_out;
  logic [0:WIDTH-1] rt_data_out;

  shift_rotate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .instruction(instruction),
    .ra_data(ra_data), .rb_data(rb_data), .stall(stall), .flush(flush),
    .valid_out(valid_out), .wr_en_out(wr_en_out), .rt_addr_out(rt_addr_out),
    .rt_data_out(rt_data_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int              checks;
  int              failures;
  int              adv;
  logic            prev_advanced;
  logic [EW-1:0]   exp_q[$];
  logic            last_v;
  logic            last_w;
  logic [6:0]      last_a;
  logic [WIDTH-1:0] last_d;
  logic [10:0]     op_tab [16];

  task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:31] mk(input logic [10:0] op, input logic [6:0] imm7,
                                     input logic [6:0] rt);
    return {op, imm7, 7'd0, rt};
  endfunction

  // Reference: element-wise integer arithmetic on the architectural rules.
  function automatic logic [WIDTH:0] ref_result(input logic [0:31] ins,
                                                input logic [0:WIDTH-1] ra,
                                                input logic [0:WIDTH-1] rb);
    logic [10:0]      op;
    int               k;
    bit               h;
    bit               m;
    bit               ok;
    longint unsigned  n, mask, a, c, s, r, ss;
    longint           sa;
    int               i7v;
    int               sh;
    logic [WIDTH-1:0] rav, rbv, acc;
    op = ins[0:10];
    ok = 1; k = 0; h = 0; m = 0;
    case (op)
      11'b00001011000: begin k = 0; h = 0; m = 0; end
      11'b00001111000: begin k = 0; h = 0; m = 1; end
      11'b00001011100: begin k = 0; h = 1; m = 0; end
      11'b00001111100: begin k = 0; h = 1; m = 1; end
      11'b00001011011: begin k = 1; h = 0; m = 0; end
      11'b00001111011: begin k = 1; h = 0; m = 1; end
      11'b00001011111: begin k = 1; h = 1; m = 0; end
      11'b00001111111: begin k = 1; h = 1; m = 1; end
      11'b00001011001: begin k = 2; h = 0; m = 0; end
      11'b00001111001: begin k = 2; h = 0; m = 1; end
      11'b00001011101: begin k = 2; h = 1; m = 0; end
      11'b00001111101: begin k = 2; h = 1; m = 1; end
      11'b00001011010: begin k = 3; h = 0; m = 0; end
      11'b00001111010: begin k = 3; h = 0; m = 1; end
      11'b00001011110: begin k = 3; h = 1; m = 0; end
      11'b00001111110: begin k = 3; h = 1; m = 1; end
      default:         ok = 0;
    endcase
    if (!ok) return '0;
    n    = h ? 16 : 32;
    mask = (64'd1 << n) - 1;
    rav  = ra;
    rbv  = rb;
    acc  = '0;
    i7v  = int'(ins[11:17]);
    if (i7v >= 64) i7v -= 128;
    for (int e = 0; e < WIDTH / int'(n); e++) begin
      sh = WIDTH - int'(n) * (e + 1);
      a  = 64'(rav >> sh) & mask;
      c  = m ? (longint'(i7v) & mask) : (64'(rbv >> sh) & mask);
      case (k)
        0: begin
          s = c % n;
          r = ((a << s) | (a >> (n - s))) & mask;
        end
        1: begin
          s = c % (2 * n);
          r = (s < n) ? ((a << s) & mask) : 0;
        end
        2: begin
          s = ((mask + 1 - c) & mask) % (2 * n);
          r = (s < n) ? (a >> s) : 0;
        end
        default: begin
          s  = ((mask + 1 - c) & mask) % (2 * n);
          ss = (s < n) ? s : n - 1;
          sa = (a >= (mask + 1) / 2) ? longint'(a) - longint'(mask + 1) : longint'(a);
          r  = longint'(sa >>> ss) & mask;
        end
      endcase
      acc = (acc << n) | WIDTH'(r);
    end
    return {1'b1, acc};
  endfunction

  // Compare the outputs produced by the previous edge against the model.
  task automatic sample();
    logic [EW-1:0] ent;
    if (prev_advanced) begin
      last_v = 0; last_w = 0; last_a = '0; last_d = '0;
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == adv) begin
        ent    = exp_q.pop_front();
        last_v = 1'b1;
        last_w = ent[WIDTH+7];
        last_a = ent[WIDTH+6 -: 7];
        last_d = ent[WIDTH-1:0];
      end
    end
    check_val("valid_out", WIDTH'(valid_out), WIDTH'(last_v));
    check_val("wr_en_out", WIDTH'(wr_en_out), WIDTH'(last_w));
    check_val("rt_addr_out", WIDTH'(rt_addr_out), WIDTH'(last_a));
    check_val("rt_data_out", rt_data_out, last_d);
  endtask

  // One clock: check, drive, then advance the model for the edge just taken.
  task automatic cycle(input logic v, input logic [0:31] ins, input logic [0:WIDTH-1] ra,
                       input logic [0:WIDTH-1] rb, input logic st, input logic fl,
                       input logic use_exp, input logic [WIDTH-1:0] exp_d,
                       input logic exp_w);
    logic [WIDTH:0] m;
    @(negedge clk);
    sample();
    valid_in    = v;
    instruction = ins;
    ra_data     = ra;
    rb_data     = rb;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      adv++;
      prev_advanced = 1'b1;
    end else if (st) begin
      prev_advanced = 1'b0;
    end else begin
      adv++;
      prev_advanced = 1'b1;
      if (v) begin
        m = use_exp ? {exp_w, exp_d} : ref_result(ins, ra, rb);
        exp_q.push_back({32'(adv + STAGES - 1), m[WIDTH], 7'(ins[25:31]), m[WIDTH-1:0]});
      end
    end
  endtask

  task automatic issue_c(input logic [0:31] ins, input logic [0:WIDTH-1] ra,
                         input logic [0:WIDTH-1] rb, input logic [WIDTH-1:0] exp_d,
                         input logic exp_w);
    cycle(1'b1, ins, ra, rb, 1'b0, 1'b0, 1'b1, exp_d, exp_w);
  endtask

  task automatic issue_m(input logic [0:31] ins, input logic [0:WIDTH-1] ra,
                         input logic [0:WIDTH-1] rb);
    cycle(1'b1, ins, ra, rb, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [0:31] rand_ins();
    logic [10:0] op;
    int          sel;
    sel = $urandom_range(0, 19);
    op  = (sel < 16) ? op_tab[sel] : 11'($urandom_range(0, 2047));
    return mk(op, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
  endfunction

  function automatic logic [0:WIDTH-1] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n  = 1'b0;
    valid_in = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    #1;
    check_val("async_rst_valid", WIDTH'(valid_out), '0);
    check_val("async_rst_wr", WIDTH'(wr_en_out), '0);
    check_val("async_rst_addr", WIDTH'(rt_addr_out), '0);
    check_val("async_rst_data", rt_data_out, '0);
    exp_q.delete();
    last_v = 0; last_w = 0; last_a = '0; last_d = '0;
    prev_advanced = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [0:31] hold_ins;
    checks = 0; failures = 0; adv = 0; prev_advanced = 1'b1;
    last_v = 0; last_w = 0; last_a = '0; last_d = '0;
    op_tab[0]  = 11'b00001011000; op_tab[1]  = 11'b00001111000;
    op_tab[2]  = 11'b00001011100; op_tab[3]  = 11'b00001111100;
    op_tab[4]  = 11'b00001011011; op_tab[5]  = 11'b00001111011;
    op_tab[6]  = 11'b00001011111; op_tab[7]  = 11'b00001111111;
    op_tab[8]  = 11'b00001011001; op_tab[9]  = 11'b00001111001;
    op_tab[10] = 11'b00001011101; op_tab[11] = 11'b00001111101;
    op_tab[12] = 11'b00001011010; op_tab[13] = 11'b00001111010;
    op_tab[14] = 11'b00001011110; op_tab[15] = 11'b00001111110;

    reset_n = 1'b0; valid_in = 1'b0; instruction = '0;
    ra_data = '0; rb_data = '0; stall = 1'b0; flush = 1'b0;
    #1;
    check_val("reset_valid", WIDTH'(valid_out), '0);
    check_val("reset_wr", WIDTH'(wr_en_out), '0);
    check_val("reset_addr", WIDTH'(rt_addr_out), '0);
    check_val("reset_data", rt_data_out, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases with hand-derived results.
    issue_c(mk(11'b00001111000, 7'd4, 7'd3), {4{32'h80000001}}, '0,
            {4{32'h00000018}}, 1'b1);
    issue_c(mk(11'b00001011000, 7'd0, 7'd5), {4{32'h12345678}},
            {32'd33, 32'd32, 32'd0, 32'd1},
            {32'h2468ACF0, 32'h12345678, 32'h12345678, 32'h2468ACF0}, 1'b1);
    issue_c(mk(11'b00001011111, 7'd0, 7'd7), {8{16'hFFFF}},
            {2{16'd16, 16'd15, 16'd31, 16'd1}},
            {2{16'h0000, 16'h8000, 16'h0000, 16'hFFFE}}, 1'b1);
    issue_c(mk(11'b00001011010, 7'd0, 7'd9), {4{32'h80000000}}, {4{32'hFFFFFFD8}},
            {4{32'hFFFFFFFF}}, 1'b1);
    issue_c(mk(11'b00001111001, 7'b1111100, 7'd11), {4{32'hF0000000}}, '0,
            {4{32'h0F000000}}, 1'b1);
    issue_c(mk(11'b00001111010, 7'b1111100, 7'd13), {4{32'hF0000000}}, '0,
            {4{32'hFF000000}}, 1'b1);
    issue_c(mk(11'b00000000000, 7'd5, 7'd15), {4{32'hDEADBEEF}}, {4{32'h1}},
            '0, 1'b0);
    idle(STAGES + 1);

    // Back-to-back with a 2-cycle stall mid-stream, then a flush carrying an op.
    for (int i = 0; i < 3; i++) issue_m(rand_ins(), rand_vec(), rand_vec());
    hold_ins = rand_ins();
    for (int i = 0; i < 2; i++)
      cycle(1'b1, hold_ins, rand_vec(), rand_vec(), 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) issue_m(rand_ins(), rand_vec(), rand_vec());
    cycle(1'b1, rand_ins(), rand_vec(), rand_vec(), 1'b0, 1'b1, 1'b0, '0, 1'b0);
    idle(STAGES + 1);

    // Reset with ops in flight.
    for (int i = 0; i < 3; i++) issue_m(rand_ins(), rand_vec(), rand_vec());
    do_reset();
    idle(STAGES + 1);

    // Random traffic with occasional stall and flush.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cycle(($urandom_range(0, 3) != 0), rand_ins(), rand_vec(), rand_vec(),
            (r < 10), (r >= 95), 1'b0, '0, 1'b0);
    end
    idle(STAGES + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
